// File: rtl/ram_arb_pkg.sv
// Shared types for the two-port RAM front-end: FSM states, port ids and
// the read-response pipeline record.
package ram_arb_pkg;

   typedef enum logic [0:0] {
      ST_INIT  = 1'b0,
      ST_SERVE = 1'b1
   } state_t;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   typedef struct packed {
      logic pending;
      logic port;
   } resp_pipe_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter; on a tie the port not granted most recently wins.
module rr_arbiter_2
   import ram_arb_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic r_last;

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (r_last == PORT_B) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end
   end

   // Pointer moves only when something is actually granted.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_last <= PORT_B;
      end else if (|gnt) begin
         r_last <= gnt[1] ? PORT_B : PORT_A;
      end
   end

endmodule

// File: rtl/ram_5x32_arbiter.sv
// Shares a single-port synchronous RAM between ports A and B after clearing
// it with an init sweep; reads return on a registered per-port path.
module ram_5x32_arbiter
   import ram_arb_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = 5,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned MEMORY_DEPTH  = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     a_valid_i,
   output logic                     a_ready_o,
   input  logic                     a_we_i,
   input  logic [ADDRESS_WIDTH-1:0] a_address_i,
   input  logic [DATA_WIDTH-1:0]    a_data_i,
   output logic                     a_rvalid_o,
   output logic [DATA_WIDTH-1:0]    a_data_o,
   input  logic                     b_valid_i,
   output logic                     b_ready_o,
   input  logic                     b_we_i,
   input  logic [ADDRESS_WIDTH-1:0] b_address_i,
   input  logic [DATA_WIDTH-1:0]    b_data_i,
   output logic                     b_rvalid_o,
   output logic [DATA_WIDTH-1:0]    b_data_o,
   output logic                     ram_we_o,
   output logic [ADDRESS_WIDTH-1:0] ram_address_o,
   output logic [DATA_WIDTH-1:0]    ram_data_o,
   input  logic [DATA_WIDTH-1:0]    ram_data_i,
   output logic                     init_done_o
);

   localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(MEMORY_DEPTH - 1);

   state_t                   r_state;
   logic [ADDRESS_WIDTH-1:0] r_init_cnt;
   resp_pipe_t               r_pipe;
   logic                     w_serve;
   logic [1:0]               w_gnt;

   assign w_serve = (r_state == ST_SERVE);

   rr_arbiter_2 u_arb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en    (w_serve),
      .req   ({b_valid_i, a_valid_i}),
      .gnt   (w_gnt)
   );

   assign a_ready_o = w_serve & a_valid_i & w_gnt[0];
   assign b_ready_o = w_serve & b_valid_i & w_gnt[1];

   // RAM mux: idle cycles issue a harmless read of address 0.
   always_comb begin
      ram_we_o      = 1'b0;
      ram_address_o = '0;
      ram_data_o    = '0;
      if (r_state == ST_INIT) begin
         ram_we_o      = 1'b1;
         ram_address_o = r_init_cnt;
      end else if (a_ready_o) begin
         ram_we_o      = a_we_i;
         ram_address_o = a_address_i;
         ram_data_o    = a_data_i;
      end else if (b_ready_o) begin
         ram_we_o      = b_we_i;
         ram_address_o = b_address_i;
         ram_data_o    = b_data_i;
      end
   end

   // FSM, response pipeline and held read data.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= ST_INIT;
         r_init_cnt  <= '0;
         init_done_o <= 1'b0;
         r_pipe      <= '0;
         a_rvalid_o  <= 1'b0;
         b_rvalid_o  <= 1'b0;
         a_data_o    <= '0;
         b_data_o    <= '0;
      end else begin
         r_pipe.pending <= (a_ready_o & ~a_we_i) | (b_ready_o & ~b_we_i);
         r_pipe.port    <= b_ready_o ? PORT_B : PORT_A;

         a_rvalid_o <= r_pipe.pending & (r_pipe.port == PORT_A);
         b_rvalid_o <= r_pipe.pending & (r_pipe.port == PORT_B);
         if (r_pipe.pending && r_pipe.port == PORT_A) a_data_o <= ram_data_i;
         if (r_pipe.pending && r_pipe.port == PORT_B) b_data_o <= ram_data_i;

         case (r_state)
            ST_INIT: begin
               r_init_cnt <= r_init_cnt + ADDRESS_WIDTH'(1);
               if (r_init_cnt == LAST_ADDR) begin
                  r_state     <= ST_SERVE;
                  init_done_o <= 1'b1;
               end
            end
            default: r_state <= ST_SERVE;
         endcase
      end
   end

endmodule
